// File: rtl/tlx_cmd_credit_arbiter_if.sv
// Command-channel bundle between AFU-side requesters, the credit arbiter
// and the TLX BFM. The arbiter uses the slave view. The requester/TLX
// side, for example a testbench, uses the master view.
interface tlx_cmd_credit_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int CMD_W   = 64,
    parameter int CRED_W  = 4
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*CMD_W-1:0] req_cmd;
    logic [NUM_REQ-1:0]       req_ready;
    logic [CRED_W-1:0]        tlx_afu_cmd_initial_credit;
    logic                     tlx_afu_cmd_initial_credit_valid;
    logic                     tlx_afu_cmd_credit;
    logic                     afu_tlx_cmd_valid;
    logic [CMD_W-1:0]         afu_tlx_cmd;
    logic [CRED_W-1:0]        credit_count;
    logic                     credit_error;

    modport master (
        output req_valid, req_cmd,
        output tlx_afu_cmd_initial_credit, tlx_afu_cmd_initial_credit_valid, tlx_afu_cmd_credit,
        input  req_ready, afu_tlx_cmd_valid, afu_tlx_cmd, credit_count, credit_error
    );

    modport slave (
        input  req_valid, req_cmd,
        input  tlx_afu_cmd_initial_credit, tlx_afu_cmd_initial_credit_valid, tlx_afu_cmd_credit,
        output req_ready, afu_tlx_cmd_valid, afu_tlx_cmd, credit_count, credit_error
    );
endinterface

// File: rtl/tlx_cmd_credit_arbiter.sv
// Round-robin arbiter that shares the AFU->TLX command channel among
// NUM_REQ requesters. A command is issued only when a TLX command credit
// is available. The module owns the credit counter. The parameters must
// match the ones of the connected interface instance.
module tlx_cmd_credit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CMD_W   = 64,
    parameter int CRED_W  = 4
) (
    input  logic                      ha_pclock,
    input  logic                      ha_preset,
    tlx_cmd_credit_arbiter_if.slave   bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CRED_W-1:0] CRED_MAX = '1;
    localparam logic [PTR_W-1:0]  LAST_REQ = PTR_W'(NUM_REQ - 1);

    typedef enum logic {WAIT_INIT, RUN} state_t;

    state_t              stateReg, stateNext;
    logic [PTR_W-1:0]    ptrReg, ptrNext;
    logic [CRED_W-1:0]   creditReg, creditNext;
    logic                errorReg, errorNext;
    logic                cmdValidReg;
    logic [CMD_W-1:0]    cmdReg;

    logic                grantHit;
    logic [PTR_W-1:0]    grantIdx;
    logic [PTR_W-1:0]    scanIdx;
    logic [CRED_W-1:0]   effCredit;
    logic [CMD_W-1:0]    cmdArr [NUM_REQ];

    // Slice the flat command bus and drive the one-hot ready vector.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign cmdArr[gi]        = bus.req_cmd[gi*CMD_W +: CMD_W];
            assign bus.req_ready[gi] = grantHit && (grantIdx == PTR_W'(gi));
        end
    endgenerate

    assign bus.afu_tlx_cmd_valid = cmdValidReg;
    assign bus.afu_tlx_cmd       = cmdReg;
    assign bus.credit_count      = creditReg;
    assign bus.credit_error      = errorReg;

    // Find the first valid requester at or after the pointer, with wrap.
    // A reload in the same cycle counts as the available credit.
    always_comb begin
        grantHit  = 1'b0;
        grantIdx  = '0;
        scanIdx   = '0;
        effCredit = bus.tlx_afu_cmd_initial_credit_valid ? bus.tlx_afu_cmd_initial_credit : creditReg;
        if (stateReg == RUN && effCredit != '0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scanIdx = PTR_W'((int'(ptrReg) + k) % NUM_REQ);
                if (!grantHit && bus.req_valid[scanIdx]) begin
                    grantHit = 1'b1;
                    grantIdx = scanIdx;
                end
            end
        end
    end

    // Next-state logic for the FSM, the pointer, the credit counter and the error flag.
    always_comb begin
        stateNext  = stateReg;
        ptrNext    = ptrReg;
        creditNext = creditReg;
        errorNext  = errorReg;
        case (stateReg)
            WAIT_INIT: begin
                // Credit returns are ignored until the first load.
                if (bus.tlx_afu_cmd_initial_credit_valid) begin
                    creditNext = bus.tlx_afu_cmd_initial_credit;
                    stateNext  = RUN;
                end
            end
            RUN: begin
                if (grantHit) begin
                    ptrNext = (grantIdx == LAST_REQ) ? '0 : grantIdx + 1'b1;
                end
                if (bus.tlx_afu_cmd_initial_credit_valid) begin
                    // A reload wins over a return or an issue in the same cycle.
                    creditNext = bus.tlx_afu_cmd_initial_credit;
                end else if (bus.tlx_afu_cmd_credit && !grantHit) begin
                    if (creditReg == CRED_MAX) begin
                        errorNext = 1'b1;
                    end else begin
                        creditNext = creditReg + 1'b1;
                    end
                end else if (grantHit && !bus.tlx_afu_cmd_credit) begin
                    // Grant gating makes an issue at zero credit unreachable.
                    // If it ever happens, it is flagged here as an underflow.
                    if (creditReg == '0) begin
                        errorNext = 1'b1;
                    end else begin
                        creditNext = creditReg - 1'b1;
                    end
                end
            end
            default: stateNext = WAIT_INIT;
        endcase
    end

    // State and output registers. On a transfer, the granted command goes out one cycle later.
    always_ff @(posedge ha_pclock) begin
        if (ha_preset) begin
            stateReg    <= WAIT_INIT;
            ptrReg      <= '0;
            creditReg   <= '0;
            errorReg    <= 1'b0;
            cmdValidReg <= 1'b0;
            cmdReg      <= '0;
        end else begin
            stateReg    <= stateNext;
            ptrReg      <= ptrNext;
            creditReg   <= creditNext;
            errorReg    <= errorNext;
            cmdValidReg <= grantHit;
            if (grantHit) begin
                cmdReg <= cmdArr[grantIdx];
            end
        end
    end
endmodule

// File: tb/tb_tlx_cmd_credit_arbiter.sv
// Directed testbench for tlx_cmd_credit_arbiter. It uses 4 requesters, CMD_W=64 and CRED_W=4.
module tb_tlx_cmd_credit_arbiter;
    logic ha_pclock = 1'b0;
    logic ha_preset;
    int   nChecks = 0;
    int   nPass   = 0;

    always #5 ha_pclock = ~ha_pclock;

    tlx_cmd_credit_arbiter_if #(.NUM_REQ(4), .CMD_W(64), .CRED_W(4)) bus ();

    tlx_cmd_credit_arbiter #(.NUM_REQ(4), .CMD_W(64), .CRED_W(4)) dut (
        .ha_pclock (ha_pclock),
        .ha_preset (ha_preset),
        .bus       (bus)
    );

    function automatic logic [63:0] cmdOf(input int i);
        return {16'hC0DE, 8'(i), 40'hA55A3CC30F};
    endfunction

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
            $display("check %-14s got=%h exp=%h ok", tag, got, exp);
        end else begin
            $display("FAIL %-14s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Each cycle drives inputs 1 time unit after the rising edge and samples 2 units later.
    task automatic cyc();
        @(posedge ha_pclock);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic ld, input logic [3:0] ldVal, input logic ret);
        bus.req_valid                        = v;
        bus.tlx_afu_cmd_initial_credit_valid = ld;
        bus.tlx_afu_cmd_initial_credit       = ldVal;
        bus.tlx_afu_cmd_credit               = ret;
    endtask

    // Checks the ready vector, the credit count and the registered command output together.
    task automatic expectCyc(input string tag, input logic [3:0] rdy, input logic [3:0] cred,
                             input logic vld, input logic [63:0] cmd);
        #2;
        checkVal({tag, ".ready"}, 64'(bus.req_ready), 64'(rdy));
        checkVal({tag, ".credit"}, 64'(bus.credit_count), 64'(cred));
        checkVal({tag, ".valid"}, 64'(bus.afu_tlx_cmd_valid), 64'(vld));
        checkVal({tag, ".cmd"}, bus.afu_tlx_cmd, cmd);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) bus.req_cmd[i*64 +: 64] = cmdOf(i);
        ha_preset = 1'b1;
        drive(4'h0, 1'b0, 4'd0, 1'b0);
        cyc(); cyc();
        expectCyc("rst", 4'h0, 4'd0, 1'b0, 64'h0);
        checkVal("rst.error", 64'(bus.credit_error), 64'h0);

        // Load 3 credits with all requesters valid. The grants go to 0, 1 and 2, then the credits run out.
        cyc(); ha_preset = 1'b0; drive(4'hF, 1'b1, 4'd3, 1'b0);
        expectCyc("t1.load", 4'h0, 4'd0, 1'b0, 64'h0);
        cyc(); drive(4'hF, 1'b0, 4'd0, 1'b0);
        expectCyc("t1.c0", 4'b0001, 4'd3, 1'b0, 64'h0);
        cyc(); expectCyc("t1.c1", 4'b0010, 4'd2, 1'b1, cmdOf(0));
        cyc(); expectCyc("t1.c2", 4'b0100, 4'd1, 1'b1, cmdOf(1));
        cyc(); expectCyc("t1.c3", 4'b0000, 4'd0, 1'b1, cmdOf(2));
        cyc(); expectCyc("t1.c4", 4'b0000, 4'd0, 1'b0, cmdOf(2));

        // The pointer is 3. Reload 8 with only requester 1 valid. It is granted in the load
        // cycle, and the load wins, so credit is 8 and the pointer is 2. Then the order is 3,1,3,1.
        cyc(); drive(4'b0010, 1'b1, 4'd8, 1'b0);
        expectCyc("t2.load", 4'b0010, 4'd0, 1'b0, cmdOf(2));
        cyc(); drive(4'b1010, 1'b0, 4'd0, 1'b0);
        expectCyc("t2.g3a", 4'b1000, 4'd8, 1'b1, cmdOf(1));
        cyc(); expectCyc("t2.g1a", 4'b0010, 4'd7, 1'b1, cmdOf(3));
        cyc(); expectCyc("t2.g3b", 4'b1000, 4'd6, 1'b1, cmdOf(1));
        cyc(); expectCyc("t2.g1b", 4'b0010, 4'd5, 1'b1, cmdOf(3));
        cyc(); drive(4'h0, 1'b0, 4'd0, 1'b0);
        expectCyc("t2.idle", 4'b0000, 4'd4, 1'b1, cmdOf(1));

        // Credit 1 with a return and an issue in the same cycle. The count stays 1 and grants
        // continue back to back from pointer 2.
        cyc(); drive(4'h0, 1'b1, 4'd1, 1'b0);
        expectCyc("t3.load", 4'b0000, 4'd4, 1'b0, cmdOf(1));
        cyc(); drive(4'hF, 1'b0, 4'd0, 1'b1);
        expectCyc("t3.g2", 4'b0100, 4'd1, 1'b0, cmdOf(1));
        cyc(); expectCyc("t3.g3", 4'b1000, 4'd1, 1'b1, cmdOf(2));
        cyc(); drive(4'hF, 1'b0, 4'd0, 1'b0);
        expectCyc("t3.g0", 4'b0001, 4'd1, 1'b1, cmdOf(3));
        cyc(); drive(4'h0, 1'b0, 4'd0, 1'b0);
        expectCyc("t3.empty", 4'b0000, 4'd0, 1'b1, cmdOf(0));
        cyc(); drive(4'hF, 1'b0, 4'd0, 1'b0);
        expectCyc("t3.zero", 4'b0000, 4'd0, 1'b0, cmdOf(0));

        // A return at 15 credits saturates the count and sets the sticky error.
        cyc(); drive(4'h0, 1'b1, 4'd15, 1'b0);
        expectCyc("t4.load", 4'b0000, 4'd0, 1'b0, cmdOf(0));
        cyc(); drive(4'h0, 1'b0, 4'd0, 1'b1);
        #2; checkVal("t4.pre_err", 64'(bus.credit_error), 64'h0);
        cyc(); drive(4'h0, 1'b0, 4'd0, 1'b0);
        #2; checkVal("t4.sat", 64'(bus.credit_count), 64'd15);
        checkVal("t4.err", 64'(bus.credit_error), 64'h1);
        cyc(); drive(4'h0, 1'b1, 4'd5, 1'b0);
        cyc(); drive(4'h0, 1'b0, 4'd0, 1'b0);
        #2; checkVal("t4.reload", 64'(bus.credit_count), 64'd5);
        checkVal("t4.sticky", 64'(bus.credit_error), 64'h1);

        // After reset, in WAIT_INIT, returns are ignored and nothing is granted.
        cyc(); ha_preset = 1'b1;
        cyc(); ha_preset = 1'b0; drive(4'hF, 1'b0, 4'd0, 1'b1);
        #2; checkVal("t5.err_clr", 64'(bus.credit_error), 64'h0);
        for (int n = 0; n < 3; n++) begin
            cyc();
            expectCyc($sformatf("t5.wait%0d", n), 4'b0000, 4'd0, 1'b0, 64'h0);
        end
        cyc(); drive(4'hF, 1'b1, 4'd2, 1'b0);
        expectCyc("t5.load", 4'b0000, 4'd0, 1'b0, 64'h0);
        cyc(); drive(4'hF, 1'b0, 4'd0, 1'b0);
        expectCyc("t5.g0", 4'b0001, 4'd2, 1'b0, 64'h0);
        cyc(); expectCyc("t5.g1", 4'b0010, 4'd1, 1'b1, cmdOf(0));

        // Assert reset in the cycle after a grant. The pending command is dropped, and the
        // pointer is back at 0.
        cyc(); ha_preset = 1'b1;
        expectCyc("t6.rst_in", 4'b0000, 4'd0, 1'b1, cmdOf(1));
        cyc(); ha_preset = 1'b0;
        expectCyc("t6.rst_out", 4'b0000, 4'd0, 1'b0, 64'h0);
        drive(4'hF, 1'b1, 4'd4, 1'b0);
        cyc(); drive(4'hF, 1'b0, 4'd0, 1'b0);
        expectCyc("t6.ptr0", 4'b0001, 4'd4, 1'b0, 64'h0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule

// File: doc/tlx_cmd_credit_arbiter.md
Name: tlx_cmd_credit_arbiter

Overview:
- Shares the single AFU->TLX command channel of the TLX BFM simulation harness among NUM_REQ requesters.
- Round-robin arbitration, gated by TLX command credits.
- Sits between the AFU-side command sources and the `tlx_bfm` command interface, clocked by `ha_pclock`.
- Owns the credit counter: initial load from TLX, return pulses, consumption per issued command. Overflow or underflow is flagged so the harness can end simulation.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CMD_W, 64, width of the opaque command bundle forwarded to TLX.
- CRED_W, 4, credit counter width; max credits = 2^CRED_W-1.

Ports:
- ha_pclock  input  1  clock.
- ha_preset  input  1  reset.
- req_valid  input  NUM_REQ  per-requester command valid.
- req_cmd  input  NUM_REQ*CMD_W  per-requester command bundle; requester i occupies bits [i*CMD_W +: CMD_W].
- req_ready  output  NUM_REQ  per-requester accept; at most one bit set.
- tlx_afu_cmd_initial_credit  input  CRED_W  credit value to load.
- tlx_afu_cmd_initial_credit_valid  input  1  load strobe.
- tlx_afu_cmd_credit  input  1  one-credit return pulse.
- afu_tlx_cmd_valid  output  1  registered command valid to TLX.
- afu_tlx_cmd  output  CMD_W  registered command bundle.
- credit_count  output  CRED_W  current credits.
- credit_error  output  1  sticky over/underflow flag.

Behaviour:
- **Clock and reset**
  - Single clock `ha_pclock`; reset `ha_preset` is synchronous, active-high.
  - Reset values: state=WAIT_INIT, credit_count=0, rr pointer=0, afu_tlx_cmd_valid=0, afu_tlx_cmd=0, credit_error=0, req_ready=0.
  - A reset asserted mid-operation discards any pending command. The following cycle shows afu_tlx_cmd_valid=0.
- **FSM**
  - WAIT_INIT: req_ready=0. On tlx_afu_cmd_initial_credit_valid, load the credit value and go to RUN.
  - RUN: normal arbitration.
  - Any further initial_credit_valid in RUN reloads the counter (the load overrides a same-cycle return or issue) and stays in RUN.
- **Arbitration in RUN**
  - Combinational. When credit_count>0 (after the same-cycle load rule), grant the first requester with req_valid=1, searching from the rr pointer upward with wrap (pointer, pointer+1, ..., NUM_REQ-1, 0, ...).
  - req_ready[g]=1 only for the granted requester, and only in RUN with credit_count>0.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- **Transfer**
  - A transfer occurs when req_valid[i] & req_ready[i].
  - Next cycle: afu_tlx_cmd_valid=1 and afu_tlx_cmd = req_cmd of requester i, a 1-cycle latency.
  - The rr pointer becomes (g+1) mod NUM_REQ. The pointer is unchanged when there is no transfer.
  - Otherwise afu_tlx_cmd_valid=0 and afu_tlx_cmd holds its last value.
- **Credit arithmetic**
  - next = credit + return - issue.
  - Same-cycle return and issue: net 0.
  - Return at max value (2^CRED_W-1) with no issue: saturate, set credit_error.
  - Issue with credit 0 cannot occur by construction. An internal assertion flags it as credit_error.
  - credit_error is sticky until reset.
- **Boundary cases**
  - Return pulses in WAIT_INIT are ignored.
  - With credit_count=0 and all requesters valid, req_ready stays 0 and the rr pointer holds.
  - A credit returned in cycle n enables a grant in cycle n+1, not n.
- **Throughput**: one command per cycle when credits are available.

Test Plan:
- Reset, then load initial credit 3; requesters 0..3 all valid continuously, no returns -> grants to 0, 1, 2 in consecutive cycles. afu_tlx_cmd_valid high for 3 cycles (one cycle delayed), then req_ready=0. credit_count goes 3, 2, 1, 0.
- Credit 8, only requesters 1 and 3 valid, rr pointer=2 -> grant order 3, 1, 3, 1. Each afu_tlx_cmd matches the granted requester's req_cmd.
- Credit 1: issue and return pulse in the same cycle -> credit_count stays 1. Back-to-back grants continue with no bubble.
- Credit count at 15 (CRED_W=4), return pulse with no issue -> credit_count stays 15 and credit_error=1. It stays set until ha_preset.
- In WAIT_INIT, all req_valid high and credit return pulses applied -> req_ready=0, credit_count=0. Then load credit 2 -> first grant in the cycle after the load.
- ha_preset asserted the cycle after a grant -> afu_tlx_cmd_valid=0 next cycle. State returns to WAIT_INIT with credit_count=0 and pointer=0.
